alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 116 +++++++++++
 tb/tb_alu_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one combinational 32-bit ALU among NUM_REQ requesters.
// One operation in flight: accept in IDLE, let the ALU settle in EXEC, hold the response in RESP.
module alu_arbiter #(
  parameter int N       = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*N-1:0] req_a,
  input  logic [NUM_REQ*N-1:0] req_b,
  input  logic [NUM_REQ*4-1:0] req_control,
  output logic [N-1:0]         alu_a,
  output logic [N-1:0]         alu_b,
  output logic [3:0]           alu_control,
  input  logic [N-1:0]         alu_result,
  input  logic                 alu_overflow,
  input  logic                 alu_zero,
  input  logic                 alu_equal,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [N-1:0]         rsp_result,
  output logic                 rsp_overflow,
  output logic                 rsp_zero,
  output logic                 rsp_equal
);

  // state  | meaning
  // S_IDLE | waiting for a request; grant goes to first valid from rr_ptr
  // S_EXEC | operands registered, ALU settling for one cycle
  // S_RESP | response held until rsp_ready
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic            grant_fire;
  logic [ID_W-1:0] rr_ptr_nxt;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_valid[wrap_idx(rr_ptr, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(rr_ptr, k);
      end
    end
  end

  assign grant_fire = (state == S_IDLE) && grant_found;
  assign rr_ptr_nxt = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);
  assign rsp_valid  = (state == S_RESP);

  always_comb begin
    req_ready = '0;
    if (grant_fire) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (grant_found) state_nxt = S_EXEC;
      S_EXEC: state_nxt = S_RESP;
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_control  <= '0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_equal    <= 1'b0;
    end else begin
      state <= state_nxt;
      // ALU operands stay put outside a grant so the shared ALU does not toggle
      if (grant_fire) begin
        alu_a       <= req_a[int'(grant_idx)*N +: N];
        alu_b       <= req_b[int'(grant_idx)*N +: N];
        alu_control <= req_control[int'(grant_idx)*4 +: 4];
        rsp_id      <= grant_idx;
        rr_ptr      <= rr_ptr_nxt;
      end
      if (state == S_EXEC) begin
        rsp_result   <= alu_result;
        rsp_overflow <= alu_overflow;
        rsp_zero     <= alu_zero;
        rsp_equal    <= alu_equal;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run against a
// transaction-level round-robin model; the shared ALU is modelled here.
module tb_alu_arbiter;
  localparam int N       = 32;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*N-1:0] req_a;
  logic [NUM_REQ*N-1:0] req_b;
  logic [NUM_REQ*4-1:0] req_control;
  logic [N-1:0]         alu_a, alu_b, alu_result;
  logic [3:0]           alu_control;
  logic                 alu_overflow, alu_zero, alu_equal;
  logic                 rsp_valid, rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [N-1:0]         rsp_result;
  logic                 rsp_overflow, rsp_zero, rsp_equal;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] r;
    logic        ov;
    logic        z;
    logic        eq;
  } alu_out_t;

  function automatic alu_out_t alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    alu_out_t o;
    logic [32:0] w;
    o.ov = 1'b0;
    case (c)
      4'b0000: o.r = a & b;
      4'b0001: o.r = a | b;
      4'b1000: begin w = {1'b0, a} + {1'b0, b}; o.r = w[31:0]; o.ov = w[32]; end
      4'b1100: begin w = {1'b0, a} - {1'b0, b}; o.r = w[31:0]; o.ov = w[32]; end
      default: o.r = a ^ b ^ {28'h0, c};
    endcase
    o.z  = (o.r == 32'h0);
    o.eq = (a == b);
    return o;
  endfunction

  alu_out_t alu_now;
  assign alu_now      = alu_ref(alu_a, alu_b, alu_control);
  assign alu_result   = alu_now.r;
  assign alu_overflow = alu_now.ov;
  assign alu_zero     = alu_now.z;
  assign alu_equal    = alu_now.eq;

  alu_arbiter #(.N(N), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_control(req_control),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .alu_equal(alu_equal),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .rsp_zero(rsp_zero), .rsp_equal(rsp_equal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    req_a[i*N +: N]       = a;
    req_b[i*N +: N]       = b;
    req_control[i*4 +: 4] = c;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  // Issues one op and waits for its response; ok=0 if either wait runs out.
  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                       output bit ok, output alu_out_t got, output logic [ID_W-1:0] id);
    bit granted = 0;
    ok = 0;
    got = '0;
    id = '0;
    rsp_ready = 1'b1;
    set_op(i, a, b, c);
    req_valid[i] = 1'b1;
    for (int w = 0; w < 30 && !granted; w++) begin
      #1;
      if (req_ready[i]) granted = 1;
      tick();
    end
    req_valid[i] = 1'b0;
    if (!granted) return;
    for (int w = 0; w < 30; w++) begin
      #1;
      if (rsp_valid) begin
        got = '{rsp_result, rsp_overflow, rsp_zero, rsp_equal};
        id  = rsp_id;
        ok  = 1;
        tick();
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_control = '0;
    #2;
    checks++;
    if ({rsp_valid, req_ready, alu_control, alu_a, alu_b, rsp_result} !== '0)
      $display("FAIL reset_outputs: got valid=%b ready=%b ctrl=%h a=%h b=%h res=%h, all zero required",
               rsp_valid, req_ready, alu_control, alu_a, alu_b, rsp_result);
    if ({rsp_valid, req_ready, alu_control, alu_a, alu_b, rsp_result} !== '0) errors++;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_add();
    rsp_ready = 1'b1;
    set_op(0, 32'd5, 32'd7, 4'b1000);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL add_grant: got %b exp 0001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_exec_valid: got %b exp 0", rsp_valid); end
    tick();
    #1;
    checks++;
    if ({rsp_valid, rsp_result, rsp_id, rsp_zero} !== {1'b1, 32'd12, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL add_rsp: got valid=%b res=%0d id=%0d zero=%b exp 1/12/0/0", rsp_valid, rsp_result, rsp_id, rsp_zero);
    end
    tick();
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_rsp_done: got %b exp 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 32'(i * 100 + 1), 32'(i + 3), 4'b1000);
    req_valid = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      int exp_id = g % NUM_REQ;
      #1;
      checks++;
      if (req_ready !== 4'(1 << exp_id)) begin
        errors++; $display("FAIL rr_grant%0d: got %b exp %b", g, req_ready, 4'(1 << exp_id));
      end
      tick();
      #1;
      checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL rr_exec%0d: got ready=%b valid=%b exp 0000/0", g, req_ready, rsp_valid);
      end
      tick();
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(exp_id) || rsp_result !== 32'(exp_id * 101 + 4)) begin
        errors++;
        $display("FAIL rr_rsp%0d: got valid=%b id=%0d res=%0d exp 1/%0d/%0d", g, rsp_valid, rsp_id, rsp_result,
                 exp_id, exp_id * 101 + 4);
      end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_flags();
    bit ok;
    alu_out_t got;
    logic [ID_W-1:0] id;
    issue(1, 32'hFFFF_FFFF, 32'd1, 4'b1000, ok, got, id);
    checks++;
    if (!ok || got !== '{32'h0, 1'b1, 1'b1, 1'b0} || id !== 2'd1) begin
      errors++; $display("FAIL flags_add_wrap: ok=%0d got %h id=%0d exp %h id=1", ok, got, id, alu_out_t'{32'h0, 1'b1, 1'b1, 1'b0});
    end
    issue(2, 32'd9, 32'd9, 4'b1100, ok, got, id);
    checks++;
    if (!ok || got !== '{32'h0, 1'b0, 1'b1, 1'b1} || id !== 2'd2) begin
      errors++; $display("FAIL flags_sub_eq: ok=%0d got %h id=%0d exp %h id=2", ok, got, id, alu_out_t'{32'h0, 1'b0, 1'b1, 1'b1});
    end
    issue(0, 32'hF0F0_0000, 32'h0FF0_0000, 4'b0111, ok, got, id);
    checks++;
    if (!ok || got !== alu_ref(32'hF0F0_0000, 32'h0FF0_0000, 4'b0111)) begin
      errors++; $display("FAIL flags_undef_op: ok=%0d got %h exp %h", ok, got, alu_ref(32'hF0F0_0000, 32'h0FF0_0000, 4'b0111));
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    set_op(3, 32'd100, 32'd23, 4'b1000);
    set_op(0, 32'd1, 32'd1, 4'b1000);
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_grant: got %b exp 1000", req_ready); end
    tick();
    req_valid = 4'b0001;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({rsp_valid, rsp_result, rsp_id, req_ready, alu_control} !== {1'b1, 32'd123, 2'd3, 4'b0000, 4'b1000}) begin
        errors++;
        $display("FAIL bp_hold%0d: got valid=%b res=%0d id=%0d ready=%b ctrl=%h exp 1/123/3/0000/8",
                 c, rsp_valid, rsp_result, rsp_id, req_ready, alu_control);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin
      errors++; $display("FAIL bp_release: got valid=%b ready=%b exp 0/0001", rsp_valid, req_ready);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_ready = 1'b0;
    set_op(1, 32'd3, 32'd4, 4'b1000);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0 || alu_control !== 4'h0) begin
      errors++; $display("FAIL rst_mid_outputs: got valid=%b ready=%b ctrl=%h exp 0/0000/0", rsp_valid, req_ready, alu_control);
    end
    #2;
    rst_n = 1'b1;
    tick();
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_mid_first_grant: got %b exp 0001", req_ready); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_exec();
    do_reset();
    rsp_ready = 1'b1;
    set_op(2, 32'd50, 32'd8, 4'b1100);
    set_op(3, 32'd1, 32'd2, 4'b1000);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL rexec_grant: got %b exp 0100", req_ready); end
    tick();
    req_valid = '0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || alu_control !== 4'h0 || alu_a !== 32'h0) begin
      errors++; $display("FAIL rexec_cleared: got valid=%b ctrl=%h a=%h exp 0/0/0", rsp_valid, alu_control, alu_a);
    end
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rexec_no_rsp: got %b exp 0", rsp_valid); end
    req_valid = 4'b1100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL rexec_ptr_zero: got %b exp 0100", req_ready); end
    tick();
    req_valid = '0;
    tick();
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd42 || rsp_id !== 2'd2) begin
      errors++; $display("FAIL rexec_reserved: got valid=%b res=%0d id=%0d exp 1/42/2", rsp_valid, rsp_result, rsp_id);
    end
    tick();
  endtask

  task automatic test_random();
    bit          pend[NUM_REQ];
    logic [31:0] pa[NUM_REQ], pb[NUM_REQ];
    logic [3:0]  pc[NUM_REQ];
    int          ptr = 0;
    int          phase = 0;   // 0 free to grant, 1 op executing, 2 response outstanding
    int          g;
    int          exp_id = 0;
    alu_out_t    exp_o = '0;
    logic [31:0] ga = '0, gb = '0;
    logic [3:0]  gc = '0;
    logic [3:0]  exp_rdy;
    logic [3:0]  ops[5] = '{4'b0000, 4'b0001, 4'b1000, 4'b1100, 4'b0110};
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1;
          pa[i] = $urandom;
          pb[i] = ($urandom_range(0, 3) == 0) ? pa[i] : 32'($urandom);
          pc[i] = ops[$urandom_range(0, 4)];
        end else if (pend[i] && $urandom_range(0, 15) == 0) begin
          pend[i] = 0;
        end
        req_valid[i] = pend[i];
        if (pend[i]) set_op(i, pa[i], pb[i], pc[i]);
      end
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      g = -1;
      if (phase == 0)
        for (int k = 0; k < NUM_REQ; k++)
          if (g < 0 && pend[(ptr + k) % NUM_REQ]) g = (ptr + k) % NUM_REQ;
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
      checks++;
      if (req_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready c%0d: got %b exp %b", cyc, req_ready, exp_rdy); end
      checks++;
      if (rsp_valid !== (phase == 2)) begin errors++; $display("FAIL rand_valid c%0d: got %b exp %b", cyc, rsp_valid, phase == 2); end
      if (phase == 1) begin
        checks++;
        if ({alu_a, alu_b, alu_control} !== {ga, gb, gc}) begin
          errors++; $display("FAIL rand_alu_ops c%0d: got %h %h %h exp %h %h %h", cyc, alu_a, alu_b, alu_control, ga, gb, gc);
        end
      end
      if (phase == 2) begin
        checks++;
        if ({rsp_result, rsp_overflow, rsp_zero, rsp_equal} !== exp_o || rsp_id !== ID_W'(exp_id)) begin
          errors++;
          $display("FAIL rand_rsp c%0d: got %h id=%0d exp %h id=%0d", cyc,
                   {rsp_result, rsp_overflow, rsp_zero, rsp_equal}, rsp_id, exp_o, exp_id);
        end
      end
      if (g >= 0) begin
        exp_o  = alu_ref(pa[g], pb[g], pc[g]);
        exp_id = g;
        ga = pa[g]; gb = pb[g]; gc = pc[g];
        pend[g] = 0;
        ptr   = (g + 1) % NUM_REQ;
        phase = 1;
      end else if (phase == 1) begin
        phase = 2;
      end else if (phase == 2 && rsp_ready) begin
        phase = 0;
      end
      tick();
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_flags();
    test_backpressure();
    test_reset_mid();
    test_reset_exec();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
